pipeline_sequencer: RTL and testbench

Run-control sequencer for the 5-stage MIPS pipeline. It accepts RUN/STEP/PAUSE commands from the debug host and converts them into pipeline-wide enables. It arbitrates the decode-stage hazard stall against jump and branch flush requests, and drains the pipeline cleanly when the decode stage detects a HALT instruction. It sits between the debug/UART command unit and the fetch, IF/ID and ID/EX stage registers.

---
 rtl/mips_seq_pkg.sv | 22 ++
 rtl/pipeline_sequencer_if.sv | 34 +++
 rtl/seq_cycle_counter.sv | 22 ++
 rtl/pipeline_sequencer.sv | 111 +++++++++++
 tb/tb_pipeline_sequencer.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_seq_pkg.sv
// rtl/mips_seq_pkg.sv - shared state, command and sizing definitions for the pipeline run-control sequencer
package mips_seq_pkg;

    // Fixed state encodings, read back by the debug host
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_STEP  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } seq_state_t;

    // Host command encodings
    localparam logic [1:0] CMD_NOP   = 2'b00;
    localparam logic [1:0] CMD_RUN   = 2'b01;
    localparam logic [1:0] CMD_STEP  = 2'b10;
    localparam logic [1:0] CMD_PAUSE = 2'b11;

    // EX, MEM and WB still hold older instructions when HALT sits in ID
    localparam int DRAIN_CYCLES_DEFAULT = 3;

endpackage

// File: rtl/pipeline_sequencer_if.sv
// rtl/pipeline_sequencer_if.sv - host command, hazard request and pipeline enable bundle
interface pipeline_sequencer_if #(
    parameter int CNT_W = 32
);
    logic             cmd_valid;
    logic [1:0]       cmd;
    logic             cmd_ready;
    logic             halt_detected;
    logic             stall_flag;
    logic             jump_req;
    logic             branch_req;
    logic             pipe_en;
    logic             pc_write;
    logic             if_id_write;
    logic             flush_if_id;
    logic             flush_id_ex;
    logic [2:0]       state;
    logic             done;
    logic [CNT_W-1:0] cycle_count;

    // Host/pipeline side: issues commands and hazard requests
    modport master (
        output cmd_valid, cmd, halt_detected, stall_flag, jump_req, branch_req,
        input  cmd_ready, pipe_en, pc_write, if_id_write, flush_if_id, flush_id_ex,
               state, done, cycle_count
    );

    // Sequencer side
    modport slave (
        input  cmd_valid, cmd, halt_detected, stall_flag, jump_req, branch_req,
        output cmd_ready, pipe_en, pc_write, if_id_write, flush_if_id, flush_id_ex,
               state, done, cycle_count
    );
endinterface

// File: rtl/seq_cycle_counter.sv
// rtl/seq_cycle_counter.sv - saturating enable counter for executed pipeline cycles
module seq_cycle_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_count
);
    logic [CNT_W-1:0] r_count;

    // Count enabled cycles, sticking at all-ones instead of wrapping
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_en && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_count = r_count;
endmodule

// File: rtl/pipeline_sequencer.sv
// rtl/pipeline_sequencer.sv - run/step/pause/drain sequencer producing pipeline enables; PIPELINE_SEQ_CYCLE_COUNTER_EN builds cycle_count
module pipeline_sequencer
    import mips_seq_pkg::*;
#(
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEFAULT,
    parameter int CNT_W        = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    pipeline_sequencer_if.slave  bus
);
    // Sized so that DRAIN_CYCLES-1 always fits, including DRAIN_CYCLES=1
    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    seq_state_t    r_state;
    logic [DW-1:0] r_drain_cnt;
    logic          r_done;

    logic w_cmd_ready;
    logic w_cmd_accept;
    logic w_halt_entry;
    logic w_pipe_en;
    logic w_fetch_ok;

    assign w_cmd_ready  = (r_state == ST_IDLE) || (r_state == ST_RUN);
    assign w_cmd_accept = bus.cmd_valid && w_cmd_ready;
    assign w_halt_entry = bus.halt_detected && ((r_state == ST_RUN) || (r_state == ST_STEP));
    assign w_pipe_en    = (r_state == ST_RUN) || (r_state == ST_STEP) || (r_state == ST_DRAIN);

    // No new fetch once HALT is in ID or while draining; a taken branch overrides a stall
    assign w_fetch_ok = w_pipe_en && (r_state != ST_DRAIN) && !w_halt_entry
                        && (!bus.stall_flag || bus.branch_req);

    // Run-control state machine with drain countdown and DONE entry pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_drain_cnt <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_cmd_accept && (bus.cmd == CMD_RUN)) begin
                        r_state <= ST_RUN;
                    end else if (w_cmd_accept && (bus.cmd == CMD_STEP)) begin
                        r_state <= ST_STEP;
                    end
                end
                ST_RUN: begin
                    if (w_halt_entry) begin
                        r_state     <= ST_DRAIN;
                        r_drain_cnt <= DW'(DRAIN_CYCLES - 1);
                    end else if (w_cmd_accept && (bus.cmd == CMD_PAUSE)) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_STEP: begin
                    if (w_halt_entry) begin
                        r_state     <= ST_DRAIN;
                        r_drain_cnt <= DW'(DRAIN_CYCLES - 1);
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    if (r_drain_cnt == '0) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_drain_cnt <= r_drain_cnt - DW'(1);
                    end
                end
                ST_DONE: begin
                    r_state <= ST_DONE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready   = w_cmd_ready;
    assign bus.pipe_en     = w_pipe_en;
    assign bus.pc_write    = w_fetch_ok;
    assign bus.if_id_write = w_fetch_ok;
    // A jump under a stall is re-decoded next cycle, so it must not flush yet
    assign bus.flush_if_id = w_pipe_en && (bus.branch_req || (bus.jump_req && !bus.stall_flag));
    assign bus.flush_id_ex = w_pipe_en && (bus.branch_req || bus.stall_flag);
    assign bus.state       = r_state;
    assign bus.done        = r_done;

`ifdef PIPELINE_SEQ_CYCLE_COUNTER_EN
    logic [CNT_W-1:0] w_cycle_count;

    seq_cycle_counter #(
        .CNT_W (CNT_W)
    ) u_cycle_counter (
        .clk     (clk),
        .reset   (reset),
        .i_en    (w_pipe_en),
        .o_count (w_cycle_count)
    );

    assign bus.cycle_count = w_cycle_count;
`else
    assign bus.cycle_count = '0;
`endif

endmodule

// File: tb/tb_pipeline_sequencer.sv
// tb/tb_pipeline_sequencer.sv - self-checking bench for pipeline_sequencer
module tb_pipeline_sequencer;
    import mips_seq_pkg::*;

    localparam int CW = 4;
    localparam int DC = 3;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    pipeline_sequencer_if #(.CNT_W(CW)) bus ();

    pipeline_sequencer #(
        .DRAIN_CYCLES (DC),
        .CNT_W        (CW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic s, j, b;
        logic pcw, ifw, fif, fie;
    } vec_t;
    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int cc(input int n);
`ifdef PIPELINE_SEQ_CYCLE_COUNTER_EN
        return (n > CMAX) ? CMAX : n;
`else
        return 0;
`endif
    endfunction

    task automatic set_in(input logic v, input logic [1:0] c, input logic h,
                          input logic s, input logic j, input logic b);
        bus.cmd_valid     = v;
        bus.cmd           = c;
        bus.halt_detected = h;
        bus.stall_flag    = s;
        bus.jump_req      = j;
        bus.branch_req    = b;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        set_in(0, CMD_NOP, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Behavioural reference: which mode the sequencer is in and how many drain cycles remain
    int m_st, m_left, m_cnt;
    bit m_done;

    initial begin
        vecs[0] = '{0,0,0, 1,1,0,0};
        vecs[1] = '{1,0,0, 0,0,0,1};
        vecs[2] = '{1,1,0, 0,0,0,1};
        vecs[3] = '{1,1,1, 1,1,1,1};
        vecs[4] = '{0,1,0, 1,1,1,0};
        vecs[5] = '{0,0,1, 1,1,1,1};
        vecs[6] = '{0,1,1, 1,1,1,1};
        vecs[7] = '{1,0,1, 1,1,1,1};

        // Reset state
        reset = 1'b0;
        set_in(0, CMD_NOP, 0, 0, 0, 0);
        #2;
        chk("rst_pipe_en", bus.pipe_en, 0);
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_state", bus.state, 0);
        chk("rst_pc_write", bus.pc_write, 0);
        chk("rst_if_id_write", bus.if_id_write, 0);
        chk("rst_flush_if_id", bus.flush_if_id, 0);
        chk("rst_flush_id_ex", bus.flush_id_ex, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_count", bus.cycle_count, 0);

        // RUN for ten cycles
        set_in(1, CMD_RUN, 0, 0, 0, 0);
        #1 chk("run_ready_before", bus.cmd_ready, 1);
        @(negedge clk);
        set_in(0, CMD_NOP, 0, 0, 0, 0);
        #1;
        chk("run_state", bus.state, 1);
        chk("run_pipe_en", bus.pipe_en, 1);
        chk("run_pc_write", bus.pc_write, 1);
        repeat (10) @(negedge clk);
        #1 chk("run_count10", bus.cycle_count, cc(10));

        // Hazard arbitration table in RUN
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            set_in(0, CMD_NOP, 0, vecs[i].s, vecs[i].j, vecs[i].b);
            #1;
            chk($sformatf("vec%0d_pc_write", i), bus.pc_write, vecs[i].pcw);
            chk($sformatf("vec%0d_if_id_write", i), bus.if_id_write, vecs[i].ifw);
            chk($sformatf("vec%0d_flush_if_id", i), bus.flush_if_id, vecs[i].fif);
            chk($sformatf("vec%0d_flush_id_ex", i), bus.flush_id_ex, vecs[i].fie);
        end

        // PAUSE returns to IDLE
        @(negedge clk);
        set_in(1, CMD_PAUSE, 0, 0, 0, 0);
        @(negedge clk);
        set_in(0, CMD_NOP, 0, 1, 1, 1);
        #1;
        chk("pause_state", bus.state, 0);
        chk("pause_flushes_gated", {bus.flush_if_id, bus.flush_id_ex, bus.pc_write}, 0);

        // Three separated STEPs
        do_reset();
        for (int k = 0; k < 3; k++) begin
            set_in(1, CMD_STEP, 0, 0, 0, 0);
            @(negedge clk);
            set_in(0, CMD_NOP, 0, 0, 0, 0);
            #1;
            chk($sformatf("step%0d_state", k), bus.state, 2);
            chk($sformatf("step%0d_pipe_en", k), bus.pipe_en, 1);
            chk($sformatf("step%0d_ready", k), bus.cmd_ready, 0);
            @(negedge clk);
            #1;
            chk($sformatf("step%0d_back_idle", k), bus.state, 0);
            chk($sformatf("step%0d_pipe_off", k), bus.pipe_en, 0);
            @(negedge clk);
        end
        #1 chk("step_count3", bus.cycle_count, cc(3));

        // HALT with simultaneous PAUSE, drain then DONE
        do_reset();
        set_in(1, CMD_RUN, 0, 0, 0, 0);
        @(negedge clk);
        set_in(1, CMD_PAUSE, 1, 0, 0, 0);
        #1;
        chk("halt_cycle_pc_write", bus.pc_write, 0);
        chk("halt_cycle_pipe_en", bus.pipe_en, 1);
        for (int i = 1; i <= DC; i++) begin
            @(negedge clk);
            set_in(0, CMD_NOP, 0, 0, 0, 0);
            #1;
            chk($sformatf("drain%0d_state", i), bus.state, 3);
            chk($sformatf("drain%0d_pipe_en", i), bus.pipe_en, 1);
            chk($sformatf("drain%0d_pc_write", i), bus.pc_write, 0);
            chk($sformatf("drain%0d_ready", i), bus.cmd_ready, 0);
        end
        @(negedge clk);
        set_in(1, CMD_RUN, 0, 0, 0, 0);
        #1;
        chk("done_state", bus.state, 4);
        chk("done_pulse", bus.done, 1);
        chk("done_pipe_en", bus.pipe_en, 0);
        @(negedge clk);
        #1;
        chk("done_pulse_end", bus.done, 0);
        chk("done_hold", bus.state, 4);
        chk("done_ready", bus.cmd_ready, 0);

        // Asynchronous reset in the middle of DRAIN
        do_reset();
        set_in(1, CMD_RUN, 0, 0, 0, 0);
        @(negedge clk);
        set_in(0, CMD_NOP, 1, 0, 0, 0);
        @(negedge clk);
        set_in(0, CMD_NOP, 0, 0, 0, 0);
        @(negedge clk);
        #1 chk("mid_drain_state", bus.state, 3);
        #1 reset = 1'b0;
        #1;
        chk("async_rst_pipe_en", bus.pipe_en, 0);
        chk("async_rst_state", bus.state, 0);
        @(negedge clk);
        reset = 1'b1;
        #1 chk("post_rst_count", bus.cycle_count, 0);
        set_in(1, CMD_RUN, 0, 0, 0, 0);
        @(negedge clk);
        set_in(0, CMD_NOP, 0, 0, 0, 0);
        #1 chk("post_rst_run", bus.state, 1);

        // Randomized run against the reference model
        do_reset();
        m_st = 0; m_left = 0; m_cnt = 0; m_done = 0;
        for (int c = 0; c < 3000; c++) begin
            logic v, h, s, j, b;
            logic [1:0] cm;
            bit e_run, e_ready, h_now, e_wr;
            int e_cc;
            @(negedge clk);
            reset = 1'b1;
            v  = ($urandom_range(1) == 1);
            cm = 2'($urandom_range(3));
            h  = ($urandom_range(29) == 0);
            s  = ($urandom_range(2) == 0);
            j  = ($urandom_range(3) == 0);
            b  = ($urandom_range(4) == 0);
            set_in(v, cm, h, s, j, b);
            if ($urandom_range(59) == 0) begin
                #1 reset = 1'b0;
                m_st = 0; m_left = 0; m_cnt = 0; m_done = 0;
            end
            #1;
            e_run   = (m_st >= 1) && (m_st <= 3);
            e_ready = (m_st == 0) || (m_st == 1);
            h_now   = h && (m_st == 1 || m_st == 2);
            e_wr    = e_run && (m_st != 3) && !h_now && (!s || b);
`ifdef PIPELINE_SEQ_CYCLE_COUNTER_EN
            e_cc = m_cnt;
`else
            e_cc = 0;
`endif
            chk("rnd_state", bus.state, m_st);
            chk("rnd_pipe_en", bus.pipe_en, e_run);
            chk("rnd_cmd_ready", bus.cmd_ready, e_ready);
            chk("rnd_pc_write", bus.pc_write, e_wr);
            chk("rnd_if_id_write", bus.if_id_write, e_wr);
            chk("rnd_flush_if_id", bus.flush_if_id, e_run && (b || (j && !s)));
            chk("rnd_flush_id_ex", bus.flush_id_ex, e_run && (b || s));
            chk("rnd_done", bus.done, m_done);
            chk("rnd_count", bus.cycle_count, e_cc);
            if (reset) begin
                if (e_run) m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
                m_done = 0;
                case (m_st)
                    0: if (v && cm == CMD_RUN) m_st = 1;
                       else if (v && cm == CMD_STEP) m_st = 2;
                    1: if (h) begin m_st = 3; m_left = DC; end
                       else if (v && cm == CMD_PAUSE) m_st = 0;
                    2: if (h) begin m_st = 3; m_left = DC; end
                       else m_st = 0;
                    3: begin
                        m_left--;
                        if (m_left == 0) begin m_st = 4; m_done = 1; end
                    end
                    default: ;
                endcase
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
